// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: turns strobe-toggled LCD output words into timed HD44780 write cycles.
// Define LCD_INIT_EN to add the power-up delay and fixed init command sequence.
module lcd_bus_ctrl #(
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 25,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 1850,
    parameter int T_CLR_CYC   = 76000,
    parameter int T_PWRUP_CYC = 750000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lcd_word_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ovf_o,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o
);
    // state      | meaning
    // IDLE       | bus parked, waiting for a request or a pending entry
    // SETUP      | RS/DATA driven, EN low
    // PULSE      | EN high
    // HOLD       | EN low, RS/DATA still held
    // WAIT       | LCD executing the command
    // INIT_PWR   | power-up delay (LCD_INIT_EN only)
    // INIT_CMD   | load next init command onto the bus (LCD_INIT_EN only)

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max_i(max_i(max_i(T_SETUP_CYC, T_EN_CYC),
                                         max_i(T_HOLD_CYC, T_CMD_CYC)),
                                   max_i(T_CLR_CYC, T_PWRUP_CYC));
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(T_EN_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD_CYC - 1);
    localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD_CYC - 1);
    localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR_CYC - 1);

`ifdef LCD_INIT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_INIT_PWR, S_INIT_CMD
    } state_t;
    localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP_CYC - 1);
    localparam state_t        RST_STATE = S_INIT_PWR;
    localparam logic [CW-1:0] RST_CNT   = LD_PWRUP;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
    } state_t;
    localparam state_t        RST_STATE = S_IDLE;
    localparam logic [CW-1:0] RST_CNT   = '0;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            strobe_q;
    logic            on_q;
    logic            req;
    logic            take_req;
    logic            take_pend;
    logic            pend_v_q;
    logic            pend_rs_q;
    logic [7:0]      pend_data_q;
    logic            rs_q;
    logic [7:0]      data_q;
    logic            ovf_q;
    logic            long_wait;
    logic            wait_end;
    logic            done_ok;
    logic            unused_word;

    assign unused_word = ^{lcd_word_i[30:11], lcd_word_i[8]};

    assign req = lcd_word_i[10] ^ strobe_q;

    // Clear and return-home need the long execution wait.
    assign long_wait = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
    assign wait_end  = (state_q == S_WAIT) && (cnt_q == '0);

`ifdef LCD_INIT_EN
    logic       init_act_q;
    logic [1:0] init_idx_q;
    logic [7:0] init_data;
    logic       take_init;

    always_comb begin
        case (init_idx_q)
            2'd0:    init_data = 8'h38;
            2'd1:    init_data = 8'h0C;
            2'd2:    init_data = 8'h01;
            default: init_data = 8'h06;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_act_q <= 1'b1;
            init_idx_q <= 2'd0;
        end else if (wait_end && init_act_q) begin
            if (init_idx_q == 2'd3) begin
                init_act_q <= 1'b0;
            end else begin
                init_idx_q <= init_idx_q + 2'd1;
            end
        end
    end

    assign done_ok = wait_end && !init_act_q;
`else
    assign done_ok = wait_end;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RST_STATE;
            cnt_q   <= RST_CNT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        take_req  = 1'b0;
        take_pend = 1'b0;
`ifdef LCD_INIT_EN
        take_init = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pend_v_q) begin
                    state_d   = S_SETUP;
                    cnt_d     = LD_SETUP;
                    take_pend = 1'b1;
                end else if (req) begin
                    state_d  = S_SETUP;
                    cnt_d    = LD_SETUP;
                    take_req = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_EN;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT;
                    cnt_d   = long_wait ? LD_CLR : LD_CMD;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
`ifdef LCD_INIT_EN
                    if (init_act_q && (init_idx_q != 2'd3)) begin
                        state_d = S_INIT_CMD;
                    end
`endif
                end
            end
`ifdef LCD_INIT_EN
            S_INIT_PWR: begin
                if (cnt_q == '0) begin
                    state_d = S_INIT_CMD;
                end
            end
            S_INIT_CMD: begin
                state_d   = S_SETUP;
                cnt_d     = LD_SETUP;
                take_init = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        lcd_en_o = (state_q == S_PULSE);
        busy_o   = (state_q != S_IDLE) || pend_v_q;
        done_o   = done_ok;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            strobe_q <= 1'b0;
            on_q     <= 1'b0;
        end else begin
            strobe_q <= lcd_word_i[10];
            on_q     <= lcd_word_i[31];
        end
    end

    // Bus snapshot and the one-deep pending buffer. A request that is not
    // taken straight into SETUP lands in the buffer when it is free (or being
    // freed this cycle); otherwise it is dropped and flagged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            pend_v_q    <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_data_q <= 8'h00;
            ovf_q       <= 1'b0;
        end else begin
            if (take_pend) begin
                rs_q   <= pend_rs_q;
                data_q <= pend_data_q;
            end else if (take_req) begin
                rs_q   <= lcd_word_i[9];
                data_q <= lcd_word_i[7:0];
            end
`ifdef LCD_INIT_EN
            else if (take_init) begin
                rs_q   <= 1'b0;
                data_q <= init_data;
            end
`endif
            if (req && !take_req) begin
                if (pend_v_q && !take_pend) begin
                    ovf_q <= 1'b1;
                end else begin
                    pend_v_q    <= 1'b1;
                    pend_rs_q   <= lcd_word_i[9];
                    pend_data_q <= lcd_word_i[7:0];
                end
            end else if (take_pend) begin
                pend_v_q <= 1'b0;
            end
        end
    end

    assign ovf_o      = ovf_q;
    assign lcd_on_o   = on_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;
    assign lcd_rw_o   = 1'b0;

endmodule
